// File: rtl/wired_lsu_sbuf_pkg.sv
// Shared wired0 defines for the LSU store buffer: default-config entry layout,
// address field positions and the tag-snoop hit helper.
package wired_lsu_sbuf_pkg;

  localparam int unsigned PADDR_W = 32;
  localparam int unsigned PPN_W   = 20;

  typedef struct packed {
    logic [31:0] paddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [3:0]  hit;
    logic        uc;
  } sb_meta_t;

  // A rewritten tag grants write hit only when its PPN matches and it carries write permission.
  function automatic logic tag_wr_hit(input logic [PPN_W-1:0] ppn,
                                      input logic [PADDR_W-1:0] paddr,
                                      input logic wp);
    return (ppn == paddr[31:12]) && wp;
  endfunction

endpackage

// File: rtl/wired_lsu_sbuf_age_sel.sv
// Per-byte youngest-match select for store-to-load forwarding: walks entries
// from oldest (head) to youngest so the last hit per byte wins.
module wired_sbuf_age_sel
  import wired_lsu_sbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NB    = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]          match_i,
  input  logic [DEPTH-1:0][NB-1:0]  strb_i,
  input  logic [IW-1:0]             head_i,
  output logic [NB-1:0]             sel_vld_o,
  output logic [NB-1:0][IW-1:0]     sel_idx_o
);

  logic [IW-1:0] idx_s;
  logic          take_s;

  // Age-ordered scan; younger hits overwrite older ones byte by byte.
  always_comb begin
    sel_vld_o = '0;
    sel_idx_o = '0;
    idx_s     = '0;
    take_s    = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        idx_s        = head_i + IW'(a);
        take_s       = match_i[idx_s] && strb_i[idx_s][b];
        sel_vld_o[b] = sel_vld_o[b] | take_s;
        sel_idx_o[b] = take_s ? idx_s : sel_idx_o[b];
      end
    end
  end

endmodule

// File: rtl/wired_lsu_sbuf_chk.sv
// Protocol checks for the store buffer: commit must target an uncommitted
// entry and occupancy can never exceed the entry count.
module wired_lsu_sbuf_chk #(
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          commit_i,
  input logic [PW-1:0] cmt_ptr,
  input logic [PW-1:0] tail_ptr,
  input logic [PW-1:0] count
);

  // Sampled on the active edge while out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(commit_i && (cmt_ptr == tail_ptr)))
        else $error("sbuf: commit with no uncommitted entry");
      assert (count <= PW'(DEPTH))
        else $error("sbuf: occupancy above depth");
    end
  end

endmodule

// File: rtl/wired_lsu_sbuf.sv
// LSU store buffer: circular FIFO with head/commit/tail pointers, byte-wise
// store-to-load forwarding and dcache tag-write snooping of per-entry hit ways.
module wired_lsu_sbuf
  import wired_lsu_sbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WAYS   = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_valid_i,
  output logic                      push_ready_o,
  input  logic [31:0]               push_paddr_i,
  input  logic [DATA_W/8-1:0]       push_strb_i,
  input  logic [DATA_W-1:0]         push_wdata_i,
  input  logic [WAYS-1:0]           push_hit_i,
  input  logic                      push_uc_i,
  input  logic                      commit_i,
  output logic                      top_hit_o,
  output logic                      drain_valid_o,
  input  logic                      drain_ready_i,
  output logic [31:0]               drain_paddr_o,
  output logic [DATA_W/8-1:0]       drain_strb_o,
  output logic [DATA_W-1:0]         drain_wdata_o,
  output logic [WAYS-1:0]           drain_hit_o,
  output logic                      drain_uc_o,
  input  logic                      flush_i,
  input  logic [31:0]               fwd_paddr_i,
  output logic [DATA_W/8-1:0]       fwd_strb_o,
  output logic [DATA_W-1:0]         fwd_data_o,
  input  logic [WAYS-1:0]           snp_twe_i,
  input  logic [31:0]               snp_taddr_i,
  input  logic [19:0]               snp_ppn_i,
  input  logic                      snp_wp_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int NB = DATA_W / 8;

  logic [PW-1:0] head_r, cmt_r, tail_r;
  logic [PW-1:0] head_nx_s, cmt_nx_s, tail_nx_s;
  logic [PW-1:0] count_s;
  logic [IW-1:0] head_idx_s, cmt_idx_s, tail_idx_s;

  logic [31:0]               paddr_r [DEPTH];
  logic [DEPTH-1:0][NB-1:0]  strb_r;
  logic [DATA_W-1:0]         wdata_r [DEPTH];
  logic [WAYS-1:0]           hit_r   [DEPTH];
  logic [DEPTH-1:0]          uc_r;

  logic [WAYS-1:0]  hit_nx_s    [DEPTH];
  logic [31:0]      ent_paddr_s [DEPTH];
  logic [DEPTH-1:0] ent_we_s;

  logic             push_fire_s, drain_fire_s, commit_ok_s;
  logic             full_s;
  logic [IW-1:0]    age_s [DEPTH];
  logic [DEPTH-1:0] occ_s, match_s;
  logic [NB-1:0]          sel_vld_s;
  logic [NB-1:0][IW-1:0]  sel_idx_s;
  logic                   unused_ok_s;

  assign head_idx_s = head_r[IW-1:0];
  assign cmt_idx_s  = cmt_r[IW-1:0];
  assign tail_idx_s = tail_r[IW-1:0];

  assign count_s      = tail_r - head_r;
  assign full_s       = (count_s == PW'(DEPTH));
  assign push_ready_o = !full_s && !flush_i;
  assign push_fire_s  = push_valid_i && push_ready_o;
  assign drain_valid_o = (head_r != cmt_r);
  assign drain_fire_s  = drain_valid_o && drain_ready_i;
  // A store pushed this cycle sits at tail, so it is never the commit target yet.
  assign commit_ok_s   = commit_i && (cmt_r != tail_r);

  assign count_o = count_s;
  assign empty_o = (count_s == {PW{1'b0}});
  assign full_o  = full_s;

  assign unused_ok_s = ^{fwd_paddr_i[1:0], snp_taddr_i[31:12], snp_taddr_i[3:0]};

  // Same-cycle ordering: drain, commit, then flush rewinds tail, else push.
  always_comb begin
    head_nx_s = head_r + {{IW{1'b0}}, drain_fire_s};
    cmt_nx_s  = cmt_r + {{IW{1'b0}}, commit_ok_s};
    if (flush_i) begin
      tail_nx_s = cmt_nx_s;
    end else if (push_fire_s) begin
      tail_nx_s = tail_r + {{IW{1'b0}}, 1'b1};
    end else begin
      tail_nx_s = tail_r;
    end
  end

  // Pointer registers; reset drops every entry, committed or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {PW{1'b0}};
      cmt_r  <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
    end else begin
      head_r <= head_nx_s;
      cmt_r  <= cmt_nx_s;
      tail_r <= tail_nx_s;
    end
  end

  // Entry payload capture at tail.
  always_ff @(posedge clk) begin
    if (push_fire_s) begin
      paddr_r[tail_idx_s] <= push_paddr_i;
      strb_r[tail_idx_s]  <= push_strb_i;
      wdata_r[tail_idx_s] <= push_wdata_i;
      uc_r[tail_idx_s]    <= push_uc_i;
    end
  end

  // Hit-way next state: push value first, then any matching tag write overrides it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_we_s[i]    = push_fire_s && (tail_idx_s == IW'(i));
      ent_paddr_s[i] = ent_we_s[i] ? push_paddr_i : paddr_r[i];
      hit_nx_s[i]    = ent_we_s[i] ? push_hit_i : hit_r[i];
      for (int w = 0; w < WAYS; w++) begin
        hit_nx_s[i][w] = (snp_twe_i[w] && (ent_paddr_s[i][11:4] == snp_taddr_i[11:4]))
                       ? tag_wr_hit(snp_ppn_i, ent_paddr_s[i], snp_wp_i)
                       : hit_nx_s[i][w];
      end
    end
  end

  // Hit-way registers, refreshed every cycle.
  always_ff @(posedge clk) begin
    hit_r <= hit_nx_s;
  end

  // Word-address match over occupied slots (head..tail-1).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_s[i]   = IW'(i) - head_idx_s;
      occ_s[i]   = ({1'b0, age_s[i]} < count_s);
      match_s[i] = occ_s[i] && (paddr_r[i][31:2] == fwd_paddr_i[31:2]);
    end
  end

  wired_sbuf_age_sel #(
    .DEPTH (DEPTH),
    .NB    (NB),
    .IW    (IW)
  ) u_age_sel (
    .match_i   (match_s),
    .strb_i    (strb_r),
    .head_i    (head_idx_s),
    .sel_vld_o (sel_vld_s),
    .sel_idx_o (sel_idx_s)
  );

  // Forwarded bytes, zero where no entry supplies the byte.
  always_comb begin
    fwd_data_o = {DATA_W{1'b0}};
    for (int b = 0; b < NB; b++) begin
      fwd_data_o[b*8 +: 8] = sel_vld_s[b] ? wdata_r[sel_idx_s[b]][b*8 +: 8] : 8'h00;
    end
  end

  assign fwd_strb_o    = sel_vld_s;
  assign drain_paddr_o = paddr_r[head_idx_s];
  assign drain_strb_o  = strb_r[head_idx_s];
  assign drain_wdata_o = wdata_r[head_idx_s];
  assign drain_hit_o   = hit_r[head_idx_s];
  assign drain_uc_o    = uc_r[head_idx_s];
  assign top_hit_o     = (cmt_r != tail_r) && (|hit_r[cmt_idx_s]);

  wired_lsu_sbuf_chk #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .commit_i (commit_i),
    .cmt_ptr  (cmt_r),
    .tail_ptr (tail_r),
    .count    (count_s)
  );

endmodule

// File: tb/tb_wired_lsu_sbuf.sv
// Self-checking bench for wired_lsu_sbuf: directed scenarios plus random traffic
// compared against a queue-based reference model of the store buffer.
module tb_wired_lsu_sbuf;

  localparam int DEPTH = 4;
  localparam int WAYS  = 4;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic push_valid_i, push_ready_o, push_uc_i, commit_i, top_hit_o;
  logic [31:0] push_paddr_i;
  logic [NB-1:0] push_strb_i;
  logic [DW-1:0] push_wdata_i;
  logic [WAYS-1:0] push_hit_i;
  logic drain_valid_o, drain_ready_i, drain_uc_o, flush_i;
  logic [31:0] drain_paddr_o;
  logic [NB-1:0] drain_strb_o;
  logic [DW-1:0] drain_wdata_o;
  logic [WAYS-1:0] drain_hit_o;
  logic [31:0] fwd_paddr_i;
  logic [NB-1:0] fwd_strb_o;
  logic [DW-1:0] fwd_data_o;
  logic [WAYS-1:0] snp_twe_i;
  logic [31:0] snp_taddr_i;
  logic [19:0] snp_ppn_i;
  logic snp_wp_i;
  logic [$clog2(DEPTH):0] count_o;
  logic empty_o, full_o;

  wired_lsu_sbuf #(.DEPTH(DEPTH), .WAYS(WAYS), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_paddr_i(push_paddr_i), .push_strb_i(push_strb_i),
    .push_wdata_i(push_wdata_i), .push_hit_i(push_hit_i), .push_uc_i(push_uc_i),
    .commit_i(commit_i), .top_hit_o(top_hit_o),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .drain_paddr_o(drain_paddr_o), .drain_strb_o(drain_strb_o),
    .drain_wdata_o(drain_wdata_o), .drain_hit_o(drain_hit_o), .drain_uc_o(drain_uc_o),
    .flush_i(flush_i), .fwd_paddr_i(fwd_paddr_i),
    .fwd_strb_o(fwd_strb_o), .fwd_data_o(fwd_data_o),
    .snp_twe_i(snp_twe_i), .snp_taddr_i(snp_taddr_i),
    .snp_ppn_i(snp_ppn_i), .snp_wp_i(snp_wp_i),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   paddr;
    logic [NB-1:0] strb;
    logic [DW-1:0] wdata;
    logic [WAYS-1:0] hit;
    logic          uc;
  } ent_t;

  ent_t q[$];
  int   ncmt;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] addrs [6];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    rst = 1'b0; push_valid_i = 1'b0; push_paddr_i = 32'h0; push_strb_i = '0;
    push_wdata_i = '0; push_hit_i = '0; push_uc_i = 1'b0; commit_i = 1'b0;
    drain_ready_i = 1'b0; flush_i = 1'b0; fwd_paddr_i = 32'h0;
    snp_twe_i = '0; snp_taddr_i = 32'h0; snp_ppn_i = 20'h0; snp_wp_i = 1'b0;
  endtask

  task automatic check_all();
    int n;
    logic [NB-1:0] es;
    logic [DW-1:0] ed;
    logic exp_top;
    n = q.size();
    check("count", 64'(count_o), 64'(n));
    check("empty", 64'(empty_o), 64'(n == 0));
    check("full", 64'(full_o), 64'(n == DEPTH));
    check("push_ready", 64'(push_ready_o), 64'((n != DEPTH) && !flush_i));
    check("drain_valid", 64'(drain_valid_o), 64'(ncmt > 0));
    if (ncmt > 0) begin
      check("drain_paddr", 64'(drain_paddr_o), 64'(q[0].paddr));
      check("drain_strb", 64'(drain_strb_o), 64'(q[0].strb));
      check("drain_wdata", 64'(drain_wdata_o), 64'(q[0].wdata));
      check("drain_hit", 64'(drain_hit_o), 64'(q[0].hit));
      check("drain_uc", 64'(drain_uc_o), 64'(q[0].uc));
    end
    exp_top = (ncmt < n) ? (|q[ncmt].hit) : 1'b0;
    check("top_hit", 64'(top_hit_o), 64'(exp_top));
    es = '0;
    ed = '0;
    foreach (q[i]) begin
      if (q[i].paddr[31:2] == fwd_paddr_i[31:2]) begin
        for (int b = 0; b < NB; b++) begin
          if (q[i].strb[b]) begin
            es[b] = 1'b1;
            ed[b*8 +: 8] = q[i].wdata[b*8 +: 8];
          end
        end
      end
    end
    check("fwd_strb", 64'(fwd_strb_o), 64'(es));
    check("fwd_data", 64'(fwd_data_o), 64'(ed));
  endtask

  task automatic model_update();
    ent_t e;
    logic push_acc;
    if (rst) begin
      q.delete();
      ncmt = 0;
    end else begin
      push_acc = push_valid_i && (q.size() != DEPTH) && !flush_i;
      if (ncmt > 0 && drain_ready_i) begin
        void'(q.pop_front());
        ncmt--;
      end
      if (commit_i && ncmt < q.size()) ncmt++;
      if (flush_i) while (q.size() > ncmt) void'(q.pop_back());
      if (push_acc) begin
        e.paddr = push_paddr_i; e.strb = push_strb_i; e.wdata = push_wdata_i;
        e.hit = push_hit_i; e.uc = push_uc_i;
        q.push_back(e);
      end
      foreach (q[i]) begin
        for (int w = 0; w < WAYS; w++) begin
          if (snp_twe_i[w] && q[i].paddr[11:4] == snp_taddr_i[11:4])
            q[i].hit[w] = (snp_ppn_i == q[i].paddr[31:12]) && snp_wp_i;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
    idle();
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [NB-1:0] s, input logic [DW-1:0] d,
                      input logic [WAYS-1:0] h);
    push_valid_i = 1'b1; push_paddr_i = a; push_strb_i = s; push_wdata_i = d;
    push_hit_i = h; push_uc_i = a[31];
    tick();
  endtask

  task automatic drain_all();
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      commit_i = (ncmt < q.size());
      drain_ready_i = 1'b1;
      tick();
    end
    check("drain_all_empty", 64'(empty_o), 64'd1);
  endtask

  initial begin
    addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0104; addrs[2] = 32'h8000_1230;
    addrs[3] = 32'h8000_1234; addrs[4] = 32'h1234_5230; addrs[5] = 32'h0000_0200;
    idle();
    rst = 1'b1;
    q.delete();
    ncmt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_push_ready", 64'(push_ready_o), 64'd1);
    check("rst_drain_valid", 64'(drain_valid_o), 64'd0);
    check("rst_top_hit", 64'(top_hit_o), 64'd0);
    check("rst_fwd_strb", 64'(fwd_strb_o), 64'd0);
    check("rst_fwd_data", 64'(fwd_data_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    tick();

    // Fill to full
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 4'hF, $urandom, 4'h0);
    check("full_flag", 64'(full_o), 64'd1);
    check("full_ready", 64'(push_ready_o), 64'd0);
    check("full_count", 64'(count_o), 64'd4);
    push(32'h110, 4'hF, 32'hDEAD_BEEF, 4'h0);
    drain_all();

    // Byte-wise forwarding, youngest wins
    push(32'h200, 4'b0011, 32'h0000_AAAA, 4'h0);
    push(32'h200, 4'b0110, 32'h00BB_BB00, 4'h0);
    fwd_paddr_i = 32'h200;
    #1;
    check("fwd_vec_strb", 64'(fwd_strb_o), 64'h7);
    check("fwd_vec_data", 64'(fwd_data_o), 64'h00BB_BBAA);
    tick();
    drain_all();

    // Commit one, flush the rest
    push(32'h300, 4'hF, 32'h1111_1111, 4'h0);
    push(32'h304, 4'hF, 32'h2222_2222, 4'h0);
    push(32'h308, 4'hF, 32'h3333_3333, 4'h0);
    commit_i = 1'b1; tick();
    flush_i = 1'b1; tick();
    check("flush_count", 64'(count_o), 64'd1);
    check("flush_dvalid", 64'(drain_valid_o), 64'd1);
    check("flush_dpaddr", 64'(drain_paddr_o), 64'h300);
    drain_ready_i = 1'b1; tick();
    check("flush_empty", 64'(empty_o), 64'd1);

    // Snoop sets then clears a hit way
    push(32'h8000_1230, 4'hF, 32'h5555_5555, 4'h0);
    snp_twe_i = 4'b0010; snp_taddr_i = 32'h0000_0230; snp_ppn_i = 20'h80001; snp_wp_i = 1'b1;
    tick();
    check("snp_top_hit", 64'(top_hit_o), 64'd1);
    commit_i = 1'b1; tick();
    check("snp_hit_set", 64'(drain_hit_o), 64'h2);
    snp_twe_i = 4'b0010; snp_taddr_i = 32'h0000_0230; snp_ppn_i = 20'h80001; snp_wp_i = 1'b0;
    tick();
    check("snp_hit_clr", 64'(drain_hit_o), 64'h0);
    drain_all();

    // Pointer wrap with steady push/commit/drain
    for (int i = 0; i < 10; i++) begin
      push_valid_i = 1'b1; push_paddr_i = 32'h400 + 32'(4 * i); push_strb_i = 4'hF;
      push_wdata_i = $urandom; push_hit_i = 4'h0; push_uc_i = 1'b0;
      commit_i = (ncmt < q.size());
      drain_ready_i = 1'b1;
      tick();
      check("wrap_count_le4", 64'(count_o <= 3'd4), 64'd1);
    end
    drain_all();

    // Reset while committed entries wait to drain
    push(32'h500, 4'hF, 32'hA5A5_A5A5, 4'h0);
    push(32'h504, 4'hF, 32'h5A5A_5A5A, 4'h0);
    commit_i = 1'b1; tick();
    commit_i = 1'b1; tick();
    check("rstd_dvalid_pre", 64'(drain_valid_o), 64'd1);
    drain_ready_i = 1'b1; rst = 1'b1; tick();
    check("rstd_empty", 64'(empty_o), 64'd1);
    check("rstd_dvalid", 64'(drain_valid_o), 64'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      push_valid_i = ($urandom_range(0, 3) != 0);
      push_paddr_i = addrs[$urandom_range(0, 5)];
      push_strb_i  = 4'($urandom_range(1, 15));
      push_wdata_i = $urandom;
      push_hit_i   = 4'($urandom_range(0, 15));
      push_uc_i    = 1'($urandom_range(0, 1));
      commit_i     = (ncmt < q.size()) && ($urandom_range(0, 1) == 1);
      drain_ready_i = 1'($urandom_range(0, 1));
      flush_i      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        snp_twe_i   = 4'($urandom_range(0, 15));
        snp_taddr_i = addrs[$urandom_range(0, 5)];
        snp_ppn_i   = addrs[$urandom_range(0, 5)][31:12];
        snp_wp_i    = 1'($urandom_range(0, 1));
      end
      fwd_paddr_i = addrs[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      tick();
    end
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
